// File: rtl/cache_state_array_if.sv
// Bus interface for cache_state_array: read port, write port, flush
// control and writeback handshake. The cache control logic uses the master
// modport and the state array uses the slave modport.
interface cache_state_array_if #(
   parameter int NUM_SETS        = 32,
   parameter int NUM_WAYS        = 4,
   parameter int SET_INDEX_WIDTH = $clog2(NUM_SETS),
   parameter int WAY_INDEX_WIDTH = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1
);
   logic                       rd_enable;
   logic [SET_INDEX_WIDTH-1:0] rd_set;
   logic [NUM_WAYS-1:0]        rd_valid;
   logic [NUM_WAYS-1:0]        rd_dirty;

   logic                       wr_enable;
   logic [SET_INDEX_WIDTH-1:0] wr_set;
   logic [WAY_INDEX_WIDTH-1:0] wr_way;
   logic                       wr_valid;
   logic                       wr_dirty;

   logic                       flush_start;
   logic                       flush_invalidate;
   logic                       flush_busy;
   logic                       flush_done;

   logic                       wb_req;
   logic [SET_INDEX_WIDTH-1:0] wb_set;
   logic [WAY_INDEX_WIDTH-1:0] wb_way;
   logic                       wb_ack;

   modport master (
      output rd_enable, rd_set, wr_enable, wr_set, wr_way, wr_valid, wr_dirty,
             flush_start, flush_invalidate, wb_ack,
      input  rd_valid, rd_dirty, flush_busy, flush_done, wb_req, wb_set, wb_way
   );

   modport slave (
      input  rd_enable, rd_set, wr_enable, wr_set, wr_way, wr_valid, wr_dirty,
             flush_start, flush_invalidate, wb_ack,
      output rd_valid, rd_dirty, flush_busy, flush_done, wb_req, wb_set, wb_way
   );
endinterface

// File: rtl/cache_state_array.sv
// Per-set, per-way valid/dirty state storage with a registered read port,
// same-cycle write bypass and a flush sequencer that walks every set.
// Optional feature macro: CACHE_STATE_DIRTY_EN. When defined, dirty bits are
// stored and the flush issues a writeback request for every valid+dirty line.
// When undefined, there is no dirty storage and the flush only walks the sets,
// optionally clearing valid bits.
module cache_state_array #(
   parameter int NUM_SETS        = 32,
   parameter int NUM_WAYS        = 4,
   parameter int SET_INDEX_WIDTH = $clog2(NUM_SETS),
   parameter int WAY_INDEX_WIDTH = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1
) (
   input logic                clk,
   input logic                reset,
   cache_state_array_if.slave bus
);

   typedef enum logic [1:0] {IDLE, SCAN, WB_WAIT, DONE} state_t;

   state_t                     state;
   state_t                     state_next;

   logic [NUM_WAYS-1:0]        valid_mem [NUM_SETS];
`ifdef CACHE_STATE_DIRTY_EN
   logic [NUM_WAYS-1:0]        dirty_mem [NUM_SETS];
   logic [NUM_WAYS-1:0]        clr_dirty_mask;
`else
   logic                       unused_wr_dirty;
`endif

   logic [SET_INDEX_WIDTH-1:0] set_cnt;
   logic                       inv_q;
   logic [NUM_WAYS-1:0]        pending;
   logic                       scan_hit;
   logic [WAY_INDEX_WIDTH-1:0] first_way;
   logic                       last_set;

   logic                       clr_en;
   logic [SET_INDEX_WIDTH-1:0] clr_set;
   logic [NUM_WAYS-1:0]        clr_valid_mask;
   logic [NUM_WAYS-1:0]        wb_onehot;

   logic [NUM_WAYS-1:0]        rd_row_valid;
   logic [NUM_WAYS-1:0]        rd_row_dirty;

`ifndef CACHE_STATE_DIRTY_EN
   assign unused_wr_dirty = bus.wr_dirty;
`endif

   assign last_set  = (set_cnt == SET_INDEX_WIDTH'(NUM_SETS - 1));
   assign scan_hit  = |pending;
   assign wb_onehot = NUM_WAYS'(1) << bus.wb_way;

   // Lines in the scanned set that still need a writeback (valid and dirty)
   always_comb begin
`ifdef CACHE_STATE_DIRTY_EN
      pending = valid_mem[set_cnt] & dirty_mem[set_cnt];
`else
      pending = '0;
`endif
   end

   // Lowest-indexed pending way is written back first
   always_comb begin
      first_way = '0;
      for (int w = NUM_WAYS - 1; w >= 0; w--) begin
         if (pending[w]) first_way = WAY_INDEX_WIDTH'(w);
      end
   end

   // State register; reset aborts any flush in progress without a done pulse
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // Next-state logic for the flush sequencer
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (bus.flush_start) state_next = SCAN;
         SCAN: begin
            if (scan_hit)      state_next = WB_WAIT;
            else if (last_set) state_next = DONE;
         end
         WB_WAIT: if (bus.wb_ack) state_next = SCAN;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Status outputs and the sequencer's clear request for the state storage
   always_comb begin
      bus.flush_busy = (state != IDLE);
      bus.flush_done = (state == DONE);
      bus.wb_req     = (state == WB_WAIT);
      clr_en         = 1'b0;
      clr_set        = set_cnt;
      clr_valid_mask = '0;
`ifdef CACHE_STATE_DIRTY_EN
      clr_dirty_mask = '0;
`endif
      case (state)
         SCAN: begin
            if (!scan_hit) begin
               clr_en = 1'b1;
`ifdef CACHE_STATE_DIRTY_EN
               clr_dirty_mask = '1;
`endif
               if (inv_q) clr_valid_mask = '1;
            end
         end
         WB_WAIT: begin
            if (bus.wb_ack) begin
               clr_en  = 1'b1;
               clr_set = bus.wb_set;
`ifdef CACHE_STATE_DIRTY_EN
               clr_dirty_mask = wb_onehot;
`endif
               if (inv_q) clr_valid_mask = wb_onehot;
            end
         end
         default: ;
      endcase
   end

   // Set counter, latched invalidate flag and the held writeback address
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         set_cnt    <= '0;
         inv_q      <= 1'b0;
         bus.wb_set <= '0;
         bus.wb_way <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.flush_start) begin
                  set_cnt <= '0;
                  inv_q   <= bus.flush_invalidate;
               end
            end
            SCAN: begin
               if (scan_hit) begin
                  bus.wb_set <= set_cnt;
                  bus.wb_way <= first_way;
               end else if (!last_set) begin
                  set_cnt <= set_cnt + SET_INDEX_WIDTH'(1);
               end
            end
            default: ;
         endcase
      end
   end

   // State storage; a client write lands after the sequencer clear so it wins
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int s = 0; s < NUM_SETS; s++) begin
            valid_mem[s] <= '0;
`ifdef CACHE_STATE_DIRTY_EN
            dirty_mem[s] <= '0;
`endif
         end
      end else begin
         if (clr_en) begin
            valid_mem[clr_set] <= valid_mem[clr_set] & ~clr_valid_mask;
`ifdef CACHE_STATE_DIRTY_EN
            dirty_mem[clr_set] <= dirty_mem[clr_set] & ~clr_dirty_mask;
`endif
         end
         if (bus.wr_enable) begin
            valid_mem[bus.wr_set][bus.wr_way] <= bus.wr_valid;
`ifdef CACHE_STATE_DIRTY_EN
            dirty_mem[bus.wr_set][bus.wr_way] <= bus.wr_dirty;
`endif
         end
      end
   end

   // Read row with the same-cycle write forwarded into its way
   always_comb begin
      rd_row_valid = valid_mem[bus.rd_set];
`ifdef CACHE_STATE_DIRTY_EN
      rd_row_dirty = dirty_mem[bus.rd_set];
`else
      rd_row_dirty = '0;
`endif
      if (bus.wr_enable && (bus.wr_set == bus.rd_set)) begin
         rd_row_valid[bus.wr_way] = bus.wr_valid;
`ifdef CACHE_STATE_DIRTY_EN
         rd_row_dirty[bus.wr_way] = bus.wr_dirty;
`endif
      end
   end

   // Registered read port, holds its value when no read is requested
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bus.rd_valid <= '0;
         bus.rd_dirty <= '0;
      end else if (bus.rd_enable) begin
         bus.rd_valid <= rd_row_valid;
         bus.rd_dirty <= rd_row_dirty;
      end
   end

endmodule

// File: tb/tb_cache_state_array.sv
// Self-checking bench for cache_state_array. Keeps a per-line valid/dirty
// model and derives expected reads and writeback order from it.
module tb_cache_state_array;

   localparam int NUM_SETS = 32;
   localparam int NUM_WAYS = 4;
   localparam int SW       = 5;
   localparam int WW       = 2;
`ifdef CACHE_STATE_DIRTY_EN
   localparam bit DIRTY_EN = 1'b1;
`else
   localparam bit DIRTY_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset;

   cache_state_array_if #(.NUM_SETS(NUM_SETS), .NUM_WAYS(NUM_WAYS)) bus ();

   cache_state_array #(.NUM_SETS(NUM_SETS), .NUM_WAYS(NUM_WAYS)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Free-running clock
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   bit                  modelValid [NUM_SETS][NUM_WAYS];
   bit                  modelDirty [NUM_SETS][NUM_WAYS];
   logic [NUM_WAYS-1:0] expRdValid;
   logic [NUM_WAYS-1:0] expRdDirty;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic void modelReset();
      for (int s = 0; s < NUM_SETS; s++)
         for (int w = 0; w < NUM_WAYS; w++) begin
            modelValid[s][w] = 1'b0;
            modelDirty[s][w] = 1'b0;
         end
      expRdValid = '0;
      expRdDirty = '0;
   endfunction

   function automatic logic [NUM_WAYS-1:0] rowValid(input int s);
      logic [NUM_WAYS-1:0] r;
      for (int w = 0; w < NUM_WAYS; w++) r[w] = modelValid[s][w];
      return r;
   endfunction

   function automatic logic [NUM_WAYS-1:0] rowDirty(input int s);
      logic [NUM_WAYS-1:0] r;
      for (int w = 0; w < NUM_WAYS; w++) r[w] = modelDirty[s][w];
      return r;
   endfunction

   // One clock of client traffic; called and returns at a falling edge
   task automatic applyStimulus(input bit wrEn, input int wrSet, input int wrWay, input bit wrV,
                                input bit wrD, input bit rdEn, input int rdSet);
      bus.wr_enable = wrEn;
      bus.wr_set    = SW'(wrSet);
      bus.wr_way    = WW'(wrWay);
      bus.wr_valid  = wrV;
      bus.wr_dirty  = wrD;
      bus.rd_enable = rdEn;
      bus.rd_set    = SW'(rdSet);
      if (wrEn) begin
         modelValid[wrSet][wrWay] = wrV;
         modelDirty[wrSet][wrWay] = DIRTY_EN & wrD;
      end
      if (rdEn) begin
         expRdValid = rowValid(rdSet);
         expRdDirty = rowDirty(rdSet);
      end
      @(negedge clk);
      bus.wr_enable = 1'b0;
      bus.rd_enable = 1'b0;
   endtask

   task automatic readCheck(input int s, input string tag);
      applyStimulus(1'b0, 0, 0, 1'b0, 1'b0, 1'b1, s);
      checkOutput({tag, "_valid"}, bus.rd_valid, expRdValid);
      checkOutput({tag, "_dirty"}, bus.rd_dirty, expRdDirty);
   endtask

   // Runs one flush to completion, checking writeback order and timing
   task automatic runFlush(input bit inv, input int ackDelay, input int restartAt,
                           output int numExp, output int heldLen);
      int          expQ[$];
      int          gotQ[$];
      int          busyCnt = 0;
      int          doneAt  = 0;
      int          reqLen  = 0;
      bit          gotDone = 1'b0;
      logic [31:0] heldTag = '0;
      heldLen = 0;
      for (int s = 0; s < NUM_SETS; s++)
         for (int w = 0; w < NUM_WAYS; w++)
            if (modelValid[s][w] && modelDirty[s][w]) expQ.push_back(s * NUM_WAYS + w);
      numExp = expQ.size();
      bus.flush_start      = 1'b1;
      bus.flush_invalidate = inv;
      bus.wb_ack           = (ackDelay == 0);
      for (int c = 0; c < 3000 && !gotDone; c++) begin
         @(negedge clk);
         bus.flush_start      = (c == restartAt);
         bus.flush_invalidate = (c == restartAt) ? ~inv : inv;
         if (c == 0) checkOutput("busy_rise", bus.flush_busy, 1);
         if (bus.flush_busy) busyCnt++;
         if (bus.flush_done) begin
            gotDone = 1'b1;
            doneAt  = busyCnt;
         end
         if (bus.wb_req) begin
            if (reqLen == 0) begin
               gotQ.push_back(int'(bus.wb_set) * NUM_WAYS + int'(bus.wb_way));
               heldTag = 32'({bus.wb_set, bus.wb_way});
            end else begin
               checkOutput("wb_hold", 32'({bus.wb_set, bus.wb_way}), heldTag);
            end
            reqLen++;
            if (ackDelay == 0 || reqLen > ackDelay) begin
               bus.wb_ack = 1'b1;
               heldLen    = reqLen;
               reqLen     = 0;
            end else begin
               bus.wb_ack = 1'b0;
            end
         end else begin
            bus.wb_ack = (ackDelay == 0);
         end
      end
      bus.wb_ack      = 1'b0;
      bus.flush_start = 1'b0;
      checkOutput("flush_done_seen", 32'(gotDone), 1);
      checkOutput("wb_count", gotQ.size(), expQ.size());
      for (int i = 0; i < gotQ.size() && i < expQ.size(); i++)
         checkOutput("wb_order", gotQ[i], expQ[i]);
      if (expQ.size() == 0) begin
         checkOutput("busy_cycles", busyCnt, NUM_SETS + 1);
         checkOutput("done_at", doneAt, NUM_SETS + 1);
      end
      @(negedge clk);
      checkOutput("busy_after", bus.flush_busy, 0);
      checkOutput("done_single", bus.flush_done, 0);
      for (int s = 0; s < NUM_SETS; s++)
         for (int w = 0; w < NUM_WAYS; w++) begin
            modelDirty[s][w] = 1'b0;
            if (inv) modelValid[s][w] = 1'b0;
         end
   endtask

   // Directed sequence with a randomized read/write phase
   initial begin
      int numExp;
      int heldLen;
      int doneCnt;
      reset                = 1'b1;
      bus.rd_enable        = 1'b0;
      bus.rd_set           = '0;
      bus.wr_enable        = 1'b0;
      bus.wr_set           = '0;
      bus.wr_way           = '0;
      bus.wr_valid         = 1'b0;
      bus.wr_dirty         = 1'b0;
      bus.flush_start      = 1'b0;
      bus.flush_invalidate = 1'b0;
      bus.wb_ack           = 1'b0;
      modelReset();
      repeat (2) @(negedge clk);
      checkOutput("reset_rd_valid", bus.rd_valid, 0);
      checkOutput("reset_rd_dirty", bus.rd_dirty, 0);
      checkOutput("reset_busy", bus.flush_busy, 0);
      checkOutput("reset_done", bus.flush_done, 0);
      checkOutput("reset_wb", 32'({bus.wb_req, bus.wb_set, bus.wb_way}), 0);
      reset = 1'b0;
      @(negedge clk);

      applyStimulus(1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 5);
      checkOutput("read5_valid", bus.rd_valid, 4'b0000);
      checkOutput("read5_dirty", bus.rd_dirty, 4'b0000);

      applyStimulus(1'b1, 3, 2, 1'b1, 1'b0, 1'b0, 0);
      checkOutput("hold_no_rd", bus.rd_valid, 4'b0000);
      applyStimulus(1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 3);
      checkOutput("read3_valid", bus.rd_valid, 4'b0100);

      applyStimulus(1'b1, 7, 1, 1'b1, 1'b0, 1'b1, 7);
      checkOutput("bypass7_valid", bus.rd_valid, 4'b0010);

      applyStimulus(1'b1, 6, 0, 1'b1, 1'b1, 1'b0, 0);
      readCheck(6, "dirty6");

      for (int i = 0; i < 300; i++) begin
         applyStimulus(1'($urandom), int'($urandom_range(7, 0)), int'($urandom_range(3, 0)),
                       1'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(7, 0)));
         checkOutput("rand_rd_valid", bus.rd_valid, expRdValid);
         checkOutput("rand_rd_dirty", bus.rd_dirty, expRdDirty);
      end

      reset = 1'b1;
      modelReset();
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      applyStimulus(1'b1, 2, 0, 1'b1, 1'b0, 1'b0, 0);
      applyStimulus(1'b1, 31, 3, 1'b1, 1'b0, 1'b0, 0);
      runFlush(1'b0, 0, -1, numExp, heldLen);
      readCheck(2, "clean_flush2");
      readCheck(31, "clean_flush31");

      runFlush(1'b0, 0, 5, numExp, heldLen);
      readCheck(2, "restart_ignored2");
      checkOutput("restart_keep2", bus.rd_valid, 4'b0001);

      applyStimulus(1'b1, 0, 3, 1'b1, 1'b1, 1'b0, 0);
      applyStimulus(1'b1, 9, 0, 1'b1, 1'b1, 1'b0, 0);
      applyStimulus(1'b1, 9, 2, 1'b1, 1'b1, 1'b0, 0);
      applyStimulus(1'b1, 9, 1, 1'b1, 1'b0, 1'b0, 0);
      applyStimulus(1'b1, 12, 2, 1'b0, 1'b1, 1'b0, 0);
      runFlush(1'b1, 0, -1, numExp, heldLen);
      for (int s = 0; s < NUM_SETS; s++) begin
         applyStimulus(1'b0, 0, 0, 1'b0, 1'b0, 1'b1, s);
         checkOutput("inv_flush_valid", bus.rd_valid, 0);
         checkOutput("inv_flush_dirty", bus.rd_dirty, 0);
      end

      applyStimulus(1'b1, 4, 1, 1'b1, 1'b1, 1'b0, 0);
      runFlush(1'b0, 5, -1, numExp, heldLen);
      if (numExp > 0) checkOutput("wb_held_cycles", heldLen, 6);
      applyStimulus(1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 4);
      checkOutput("after_wb4_valid", bus.rd_valid, 4'b0010);
      checkOutput("after_wb4_dirty", bus.rd_dirty, 4'b0000);

      bus.flush_start      = 1'b1;
      bus.flush_invalidate = 1'b1;
      @(negedge clk);
      bus.flush_start = 1'b0;
      repeat (8) @(negedge clk);
      reset = 1'b1;
      #1;
      checkOutput("abort_busy", bus.flush_busy, 0);
      modelReset();
      @(negedge clk);
      reset   = 1'b0;
      doneCnt = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (bus.flush_done || bus.flush_busy) doneCnt++;
      end
      checkOutput("abort_no_done", doneCnt, 0);
      readCheck(4, "abort_read4");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
